// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit driving a req/gnt/rvalid data-memory port
module mem_access_unit #(
  parameter int XLEN             = 32,
  parameter int REG_SEL_W        = 5,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 reqValid_i,
  output logic                 reqReady_o,
  input  logic                 reqRead_i,
  input  logic                 reqWrite_i,
  input  logic [XLEN-1:0]      reqAddr_i,
  input  logic [XLEN-1:0]      reqData_i,
  input  logic [2:0]           reqOpType_i,
  input  logic [REG_SEL_W-1:0] reqRdAddr_i,
  output logic                 memReq_o,
  output logic                 memWe_o,
  output logic [XLEN-1:0]      memAddr_o,
  output logic [XLEN-1:0]      memWdata_o,
  output logic [XLEN/8-1:0]    memBe_o,
  input  logic                 memGnt_i,
  input  logic                 memRvalid_i,
  input  logic [XLEN-1:0]      memRdata_i,
  output logic                 wbDv_o,
  output logic [REG_SEL_W-1:0] wbAddr_o,
  output logic [XLEN-1:0]      wbData_o,
  output logic                 errMisalign_o,
  output logic                 errIllegal_o
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int SW = $clog2(XLEN) + 1;
  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, WB} state_t;
  state_t state, nxt;
  logic we, split, err_ill, err_mis;
  logic [2:0] op;
  logic [REG_SEL_W-1:0] rd;
  logic [OW-1:0] off, off_i;
  logic [NB-1:0] be_hi, mem_be;
  logic [XLEN-1:0] wd_hi, lo, mem_addr, mem_wdata, wb_data;
  logic [3:0] sz_i;
  logic split_i, ill_i, mis_i, accept, go, last_rv;
  logic [2*NB-1:0] be_i;
  logic [2*XLEN-1:0] wd_i, cat;
  logic [XLEN-1:0] raw, up, ext;
  logic [SW-1:0] sh;
  // Both beats are precomputed at capture as a double-word lane image; beat 2 is its upper half.
  always_comb begin
    off_i   = reqAddr_i[OW-1:0];
    sz_i    = 4'd1 << reqOpType_i[1:0];
    split_i = (8'(off_i) + 8'(sz_i)) > 8'(NB);
    ill_i   = (reqRead_i == reqWrite_i) || reqOpType_i == 3'd7 ||
              (XLEN == 32 && (reqOpType_i == 3'd3 || reqOpType_i == 3'd6)) ||
              (reqWrite_i && reqOpType_i[2]);
    mis_i   = (SPLIT_MISALIGNED == 0) && split_i;
    accept  = reqValid_i && state == IDLE;
    go      = accept && !ill_i && !mis_i;
    be_i    = ~({2*NB{1'b1}} << sz_i) << off_i;
    wd_i    = ((2*XLEN)'(reqData_i) & ~({2*XLEN{1'b1}} << {sz_i, 3'b0})) << {off_i, 3'b0};
  end
  // Load data: beat1 in the low word, beat2 above it, shifted down by the byte offset.
  always_comb begin
    last_rv = memRvalid_i && ((state == WAIT1 && !split) || state == WAIT2);
    cat     = (state == WAIT2) ? {memRdata_i, lo} : {{XLEN{1'b0}}, memRdata_i};
    raw     = XLEN'(cat >> {off, 3'b0});
    sh      = SW'(XLEN) - (SW'(8) << op[1:0]);
    up      = raw << sh;
    ext     = op[2] ? up >> sh : XLEN'($signed(up) >>> sh);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = go ? REQ1 : IDLE;
      REQ1:    nxt = !memGnt_i ? REQ1 : !we ? WAIT1 : split ? REQ2 : IDLE;
      WAIT1:   nxt = !memRvalid_i ? WAIT1 : split ? REQ2 : WB;
      REQ2:    nxt = !memGnt_i ? REQ2 : we ? IDLE : WAIT2;
      WAIT2:   nxt = memRvalid_i ? WB : WAIT2;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      we        <= 1'b0;
      split     <= 1'b0;
      op        <= '0;
      rd        <= '0;
      off       <= '0;
      be_hi     <= '0;
      wd_hi     <= '0;
      lo        <= '0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_data   <= '0;
      err_ill   <= 1'b0;
      err_mis   <= 1'b0;
    end else begin
      state   <= nxt;
      err_ill <= accept && ill_i;
      err_mis <= accept && !ill_i && mis_i;
      if (go) begin
        we        <= reqWrite_i;
        op        <= reqOpType_i;
        rd        <= reqRdAddr_i;
        off       <= off_i;
        split     <= split_i;
        mem_addr  <= {reqAddr_i[XLEN-1:OW], {OW{1'b0}}};
        mem_be    <= be_i[NB-1:0];
        mem_wdata <= wd_i[XLEN-1:0];
        be_hi     <= be_i[2*NB-1:NB];
        wd_hi     <= wd_i[2*XLEN-1:XLEN];
      end
      if (state == REQ1 && memGnt_i && split) begin
        mem_addr  <= mem_addr + XLEN'(NB);
        mem_be    <= be_hi;
        mem_wdata <= wd_hi;
      end
      if (state == WAIT1 && memRvalid_i) lo <= memRdata_i;
      if (last_rv) wb_data <= ext;
    end
  end
  assign reqReady_o    = state == IDLE;
  assign memReq_o      = state == REQ1 || state == REQ2;
  assign memWe_o       = memReq_o && we;
  assign memAddr_o     = mem_addr;
  assign memBe_o       = mem_be;
  assign memWdata_o    = mem_wdata;
  assign wbDv_o        = state == WB && rd != '0;
  assign wbAddr_o      = rd;
  assign wbData_o      = wb_data;
  assign errIllegal_o  = err_ill;
  assign errMisalign_o = err_mis;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random load/store traffic checked against a byte-memory model
module tb_mem_access_unit;
  logic clk = 0, rstn = 0;
  always #5 clk = ~clk;
  logic req_valid = 0, req_read = 0, req_write = 0, req_ready;
  logic [31:0] req_addr = 0, req_data = 0;
  logic [2:0] req_op = 0;
  logic [4:0] req_rd = 0;
  logic mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0] mem_be;
  logic wb_dv, err_mis, err_ill;
  logic [4:0] wb_addr;
  logic [31:0] wb_data;
  mem_access_unit #(.XLEN(32), .REG_SEL_W(5), .SPLIT_MISALIGNED(1)) dut (
    .clk(clk), .rstn(rstn), .reqValid_i(req_valid), .reqReady_o(req_ready),
    .reqRead_i(req_read), .reqWrite_i(req_write), .reqAddr_i(req_addr), .reqData_i(req_data),
    .reqOpType_i(req_op), .reqRdAddr_i(req_rd), .memReq_o(mem_req), .memWe_o(mem_we),
    .memAddr_o(mem_addr), .memWdata_o(mem_wdata), .memBe_o(mem_be), .memGnt_i(mem_gnt),
    .memRvalid_i(mem_rvalid), .memRdata_i(mem_rdata), .wbDv_o(wb_dv), .wbAddr_o(wb_addr),
    .wbData_o(wb_data), .errMisalign_o(err_mis), .errIllegal_o(err_ill));
  logic s_valid = 0, s_read = 0, s_write = 0, s_ready, s_req, s_we, s_gnt = 1, s_rvalid = 0;
  logic [31:0] s_addr = 0, s_data = 0, s_maddr, s_wdata, s_rdata = 0, s_wbdata;
  logic [2:0] s_op = 0;
  logic [4:0] s_rd = 0, s_wbaddr;
  logic [3:0] s_be;
  logic s_wbdv, s_err_mis, s_err_ill;
  mem_access_unit #(.XLEN(32), .REG_SEL_W(5), .SPLIT_MISALIGNED(0)) dut_nosplit (
    .clk(clk), .rstn(rstn), .reqValid_i(s_valid), .reqReady_o(s_ready),
    .reqRead_i(s_read), .reqWrite_i(s_write), .reqAddr_i(s_addr), .reqData_i(s_data),
    .reqOpType_i(s_op), .reqRdAddr_i(s_rd), .memReq_o(s_req), .memWe_o(s_we),
    .memAddr_o(s_maddr), .memWdata_o(s_wdata), .memBe_o(s_be), .memGnt_i(s_gnt),
    .memRvalid_i(s_rvalid), .memRdata_i(s_rdata), .wbDv_o(s_wbdv), .wbAddr_o(s_wbaddr),
    .wbData_o(s_wbdata), .errMisalign_o(s_err_mis), .errIllegal_o(s_err_ill));

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we;} beat_t;
  typedef struct {logic [4:0] rd; logic [31:0] data;} wb_t;
  typedef struct {int due; logic [31:0] data;} rd_t;
  beat_t exp_beats[$];
  wb_t exp_wb[$];
  rd_t pend[$];
  int exp_ill = 0;
  logic [7:0] mem [logic [31:0]];
  bit fast = 1, hold_rv = 0;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h5A);
  endfunction
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
  endfunction
  function automatic void set_word(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) mem[a + 32'(i)] = v[8*i +: 8];
  endfunction
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{be[l]}};
    return m;
  endfunction
  // Load result: little-endian bytes from the byte memory, then sign/zero extension.
  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = 0;
    n = 1 << op[1:0];
    for (int i = 0; i < n; i++) v |= 32'(rd_byte(a + 32'(i))) << (8 * i);
    if (!op[2] && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 1);
    return v;
  endfunction
  // Each accessed byte lands in the word holding it, at lane = address mod 4.
  function automatic int push_beats(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    beat_t b[2];
    logic [31:0] ba;
    int n, nb, k;
    n = 1 << op[1:0];
    nb = 1;
    for (int j = 0; j < 2; j++) begin
      b[j].addr = (a & ~32'd3) + 32'(4 * j);
      b[j].be = 0;
      b[j].wdata = 0;
      b[j].we = w;
    end
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      k = (ba[31:2] != a[31:2]) ? 1 : 0;
      if (k == 1) nb = 2;
      b[k].be[ba[1:0]] = 1'b1;
      b[k].wdata[8*ba[1:0] +: 8] = d[8*i +: 8];
    end
    for (int j = 0; j < nb; j++) exp_beats.push_back(b[j]);
    return nb;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    mem_rvalid = 0;
    mem_rdata = $urandom;
    if (pend.size() > 0) begin
      if (pend[0].due <= cyc && !hold_rv && (fast || $urandom % 3 != 0)) begin
        mem_rvalid = 1;
        mem_rdata = pend[0].data;
        void'(pend.pop_front());
      end
    end else if (!fast && $urandom % 8 == 0) mem_rvalid = 1;
    mem_gnt = mem_req && (fast || $urandom % 3 != 0);
    if (mem_gnt) begin
      if (mem_we) begin
        for (int l = 0; l < 4; l++) if (mem_be[l]) mem[mem_addr + 32'(l)] = mem_wdata[8*l +: 8];
      end else pend.push_back('{cyc + 1, rd_word(mem_addr)});
    end
  end

  beat_t mb;
  wb_t mw;
  int wb_cyc = 0, wb_seen = 0, s_req_cnt = 0;
  logic [31:0] last_wb_data = 0;
  logic [4:0] last_wb_addr = 0;
  always @(negedge clk) if (s_req) s_req_cnt++;
  always @(negedge clk) if (rstn) begin
    if (mem_req && mem_gnt) begin
      if (exp_beats.size() == 0) chk("beat_unexpected", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        mb = exp_beats.pop_front();
        chk("beat_addr", mem_addr, mb.addr);
        chk("beat_be", mem_be, mb.be);
        chk("beat_we", mem_we, mb.we);
        if (mb.we) chk("beat_wdata", mem_wdata & be_mask(mem_be), mb.wdata);
      end
    end
    if (wb_dv) begin
      wb_seen++;
      wb_cyc = cyc;
      last_wb_data = wb_data;
      last_wb_addr = wb_addr;
      if (exp_wb.size() == 0) chk("wb_unexpected", {32'd0, wb_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        mw = exp_wb.pop_front();
        chk("wb_addr", wb_addr, mw.rd);
        chk("wb_data", wb_data, mw.data);
      end
    end
    if (err_ill) begin
      if (exp_ill == 0) chk("ill_unexpected", err_ill, 0);
      else exp_ill--;
    end
    if (err_mis) chk("mis_unexpected", err_mis, 0);
  end

  task automatic start(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] op, input logic [4:0] rdst, output int c0);
    int to;
    to = 0;
    while (!req_ready && to < 200) begin
      @(posedge clk);
      #1;
      to++;
    end
    if (r == w || op == 3'd7 || op == 3'd3 || op == 3'd6 || (w && op >= 3'd3)) exp_ill++;
    else begin
      void'(push_beats(w, a, d, op));
      if (r && rdst != 0) exp_wb.push_back('{rdst, model_load(op, a)});
    end
    req_valid = 1;
    req_read = r;
    req_write = w;
    req_addr = a;
    req_data = d;
    req_op = op;
    req_rd = rdst;
    @(posedge clk);
    #1;
    c0 = cyc;
    req_valid = 0;
  endtask
  task automatic finish(input string name);
    int to;
    to = 0;
    forever begin
      @(posedge clk);
      #1;
      req_valid = !req_ready && ($urandom % 4 == 0);
      req_read = 1'($urandom);
      req_write = 1'($urandom);
      req_addr = $urandom;
      req_data = $urandom;
      req_op = 3'($urandom);
      req_rd = 5'($urandom);
      if (req_ready && exp_beats.size() == 0 && exp_wb.size() == 0 && exp_ill == 0) break;
      if (++to > 300) begin
        chk({name, "_timeout"}, 1, 0);
        exp_beats.delete();
        exp_wb.delete();
        exp_ill = 0;
        break;
      end
    end
  endtask

  int c0, n0, sel, t, seen0;
  logic r, w;
  logic [2:0] op;
  logic [31:0] lit_a [3] = '{32'h103, 32'h103, 32'h101};
  logic [2:0]  lit_op[3] = '{3'd0, 3'd4, 3'd1};
  logic [31:0] lit_v [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1122};
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr_be_wd", {mem_addr, mem_be, mem_wdata}, 0);
    chk("rst_wb", {wb_dv, wb_addr, wb_data}, 0);
    chk("rst_err", {err_ill, err_mis}, 0);
    rstn = 1;
    set_word(32'h100, 32'hDEADBEEF);
    chk("pin_lw", model_load(3'd2, 32'h100), 32'hDEADBEEF);
    start(1, 0, 32'h100, 0, 3'd2, 5'd5, c0);
    chk("lw_req_t1", mem_req, 1);
    finish("lw");
    chk("lw_latency", wb_cyc - c0, 2);
    chk("lw_addr", last_wb_addr, 5);
    chk("lw_data", last_wb_data, 32'hDEADBEEF);
    set_word(32'h100, 32'h80112233);
    for (int i = 0; i < 3; i++) begin
      chk("pin_lb_lbu_lh", model_load(lit_op[i], lit_a[i]), lit_v[i]);
      start(1, 0, lit_a[i], 0, lit_op[i], 5'd9, c0);
      finish("lb_lbu_lh");
      chk("lb_lbu_lh_data", last_wb_data, lit_v[i]);
    end
    start(0, 1, 32'h102, 32'h1234ABCD, 3'd1, 0, c0);
    chk("pin_sh", {exp_beats[0].addr, exp_beats[0].be, exp_beats[0].wdata}, {32'h100, 4'b1100, 32'hABCD0000});
    chk("sh_bus", {mem_req, mem_we, mem_addr, mem_be}, {1'b1, 1'b1, 32'h100, 4'b1100});
    chk("sh_wdata", mem_wdata & be_mask(mem_be), 32'hABCD0000);
    finish("sh");
    start(0, 1, 32'h104, 32'h0BADF00D, 3'd2, 0, c0);
    chk("sw_busy", req_ready, 0);
    @(posedge clk);
    #1;
    chk("sw_ready_t2", req_ready, 1);
    finish("sw");
    start(1, 0, 32'h100, 0, 3'd7, 5'd3, c0);
    chk("ill_op7", {err_ill, mem_req}, 2'b10);
    finish("ill_op7");
    start(1, 1, 32'h100, 0, 3'd2, 5'd3, c0);
    chk("ill_rw", {err_ill, mem_req}, 2'b10);
    finish("ill_rw");
    fast = 0;
    set_word(32'h100, 32'h44332211);
    set_word(32'h104, 32'h88776655);
    chk("pin_lw_split", model_load(3'd2, 32'h101), 32'h55443322);
    start(1, 0, 32'h101, 0, 3'd2, 5'd12, c0);
    finish("lw_split");
    chk("lw_split_data", last_wb_data, 32'h55443322);
    fast = 1;
    hold_rv = 1;
    seen0 = wb_seen;
    start(1, 0, 32'h120, 0, 3'd2, 5'd7, c0);
    for (t = 0; t < 20 && pend.size() == 0; t++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    rstn = 0;
    exp_wb.delete();
    @(posedge clk);
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_ready", req_ready, 1);
    rstn = 1;
    hold_rv = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_late_rvalid_sent", pend.size(), 0);
    chk("rst_no_wb", wb_seen - seen0, 0);
    exp_beats.delete();
    fast = 0;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom % 20;
      if (sel == 0) begin
        r = 1'($urandom);
        w = 1'($urandom);
        op = 3'($urandom);
      end else begin
        w = ($urandom % 3 == 0);
        r = !w;
        t = $urandom % 5;
        op = w ? 3'($urandom % 3) : 3'(t < 3 ? t : t + 1);
      end
      start(r, w, 32'h100 + ($urandom % 64), $urandom, op, 5'($urandom), c0);
      finish("rand");
    end
    n0 = s_req_cnt;
    s_valid = 1;
    s_write = 1;
    s_read = 0;
    s_addr = 32'h103;
    s_data = 32'h11223344;
    s_op = 3'd2;
    @(posedge clk);
    #1;
    s_valid = 0;
    chk("nosplit_mis_pulse", {s_err_mis, s_err_ill}, 2'b10);
    @(posedge clk);
    #1;
    chk("nosplit_mis_end", s_err_mis, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("nosplit_no_req", s_req_cnt - n0, 0);
    s_valid = 1;
    s_addr = 32'h101;
    s_data = 32'h000000A5;
    s_op = 3'd0;
    @(posedge clk);
    #1;
    s_valid = 0;
    chk("nosplit_sb_bus", {s_req, s_err_mis, s_maddr, s_be}, {1'b1, 1'b0, 32'h100, 4'b0010});
    chk("nosplit_sb_wdata", s_wdata[15:8], 8'hA5);
    @(posedge clk);
    #1;
    chk("nosplit_sb_done", s_ready, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
